muldiv_lat_mon: RTL and testbench

Synthesizable latency scoreboard for multi-cycle multiply/divide units with a Rocket-style MulDiv req/resp interface. It passively snoops the request and response handshakes and tracks up to DEPTH outstanding operations by tag. On each response it reports the measured latency and checks it against per-class bounds derived from XLEN. It sits beside the MulDiv in formal harnesses and in simulation, and replaces hand-written per-function latency checks.

---
 rtl/muldiv_lat_pkg.sv | 34 +++
 rtl/muldiv_lat_mon_if.sv | 42 ++++
 rtl/muldiv_lat_entry.sv | 93 +++++++++
 rtl/muldiv_lat_mon.sv | 174 +++++++++++++++++
 tb/tb_muldiv_lat_mon.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_lat_pkg.sv
// Shared types for the MulDiv latency scoreboard: operation classes,
// per-slot state record and the fn-to-class decode.
package muldiv_lat_pkg;

  localparam int MAX_TAGW = 16;
  localparam int MAX_CW   = 16;

  typedef enum logic [1:0] {
    MUL  = 2'd0,
    DIVU = 2'd1,
    DIVS = 2'd2
  } fn_class_e;

  typedef struct packed {
    logic                live;
    logic                timed_out;
    fn_class_e           cls;
    logic [3:0]          fn;
    logic [MAX_TAGW-1:0] tag;
    logic [MAX_CW-1:0]   cnt;
  } entry_t;

  // fn[2] splits multiply from divide; fn[0] marks the unsigned divide forms.
  function automatic fn_class_e fn_class(input logic [3:0] fn);
    fn_class_e cls;
    casez (fn)
      4'b?0??: cls = MUL;
      4'b?1?1: cls = DIVU;
      default: cls = DIVS;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/muldiv_lat_mon_if.sv
// Snooped MulDiv request/response handshakes together with the scoreboard's
// latency report and error pulses.
interface muldiv_lat_mon_if #(
  parameter int TAGW = 5,
  parameter int CW   = 8,
  parameter int PW   = 3
);
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_fn;
  logic [TAGW-1:0] req_tag;
  logic            kill;
  logic            resp_valid;
  logic            resp_ready;
  logic [TAGW-1:0] resp_tag;

  logic            lat_valid;
  logic [CW-1:0]   lat_cycles;
  logic [3:0]      lat_fn;
  logic [PW-1:0]   pending;
  logic            err_early;
  logic            err_late;
  logic            err_timeout;
  logic            err_orphan;
  logic            err_dup;
  logic            err_overflow;
  logic            err_any;

  modport master (
    output req_valid, req_ready, req_fn, req_tag, kill,
    output resp_valid, resp_ready, resp_tag,
    input  lat_valid, lat_cycles, lat_fn, pending,
    input  err_early, err_late, err_timeout, err_orphan, err_dup, err_overflow, err_any
  );

  modport slave (
    input  req_valid, req_ready, req_fn, req_tag, kill,
    input  resp_valid, resp_ready, resp_tag,
    output lat_valid, lat_cycles, lat_fn, pending,
    output err_early, err_late, err_timeout, err_orphan, err_dup, err_overflow, err_any
  );
endinterface

// File: rtl/muldiv_lat_entry.sv
// One tracked slot of the latency scoreboard: saturating latency counter,
// one-shot timeout detection and class bound comparison.
module muldiv_lat_entry
  import muldiv_lat_pkg::*;
#(
  parameter int TAGW     = 5,
  parameter int CW       = 8,
  parameter int MUL_MIN  = 33,
  parameter int MUL_MAX  = 33,
  parameter int DIVU_MIN = 34,
  parameter int DIVU_MAX = 34,
  parameter int DIVS_MIN = 34,
  parameter int DIVS_MAX = 36
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_i,
  input  logic                free_i,
  input  logic [3:0]          fn_i,
  input  logic [TAGW-1:0]     tag_i,
  output logic                live_o,
  output logic [MAX_TAGW-1:0] tag_o,
  output logic [3:0]          fn_o,
  output logic [CW-1:0]       lat_o,
  output logic                early_o,
  output logic                late_o,
  output logic                timeout_o
);

  localparam logic [MAX_CW-1:0] SAT = MAX_CW'((1 << CW) - 1);

  entry_t            ent_q, ent_d;
  logic [MAX_CW-1:0] min_w, max_w;

  always_comb begin
    case (ent_q.cls)
      MUL: begin
        min_w = MAX_CW'(MUL_MIN);
        max_w = MAX_CW'(MUL_MAX);
      end
      DIVU: begin
        min_w = MAX_CW'(DIVU_MIN);
        max_w = MAX_CW'(DIVU_MAX);
      end
      default: begin
        min_w = MAX_CW'(DIVS_MIN);
        max_w = MAX_CW'(DIVS_MAX);
      end
    endcase
  end

  // Allocation wins over freeing so a slot released by a response can be
  // refilled by an accept in the same cycle.
  always_comb begin
    ent_d     = ent_q;
    timeout_o = 1'b0;
    if (alloc_i) begin
      ent_d.live      = 1'b1;
      ent_d.timed_out = 1'b0;
      ent_d.cls       = fn_class(fn_i);
      ent_d.fn        = fn_i;
      ent_d.tag       = MAX_TAGW'(tag_i);
      ent_d.cnt       = MAX_CW'(1);
    end else if (free_i) begin
      ent_d.live      = 1'b0;
      ent_d.timed_out = 1'b0;
    end else if (ent_q.live) begin
      if (ent_q.cnt != SAT) begin
        ent_d.cnt = ent_q.cnt + MAX_CW'(1);
      end
      if (!ent_q.timed_out && (ent_q.cnt == max_w)) begin
        ent_d.timed_out = 1'b1;
        timeout_o       = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign live_o  = ent_q.live;
  assign tag_o   = ent_q.tag;
  assign fn_o    = ent_q.fn;
  assign lat_o   = ent_q.cnt[CW-1:0];
  assign early_o = (ent_q.cnt < min_w);
  assign late_o  = (ent_q.cnt > max_w);

endmodule

// File: rtl/muldiv_lat_mon.sv
// Passive latency scoreboard for a multi-cycle MulDiv: tracks outstanding
// operations by tag and reports latency and bound violations on each response.
module muldiv_lat_mon
  import muldiv_lat_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int TAGW     = 5,
  parameter int CW       = 8,
  parameter int MUL_MIN  = XLEN + 1,
  parameter int MUL_MAX  = XLEN + 1,
  parameter int DIVU_MIN = XLEN + 2,
  parameter int DIVU_MAX = XLEN + 2,
  parameter int DIVS_MIN = XLEN + 2,
  parameter int DIVS_MAX = XLEN + 4
) (
  input  logic            clock,
  input  logic            reset,
  muldiv_lat_mon_if.slave mon
);

  localparam int PW = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("muldiv_lat_mon: DEPTH must be within 1..16");
  end
  if (CW > MAX_CW || TAGW > MAX_TAGW) begin : g_bad_width
    $error("muldiv_lat_mon: CW or TAGW exceeds the slot storage width");
  end
  // A saturated counter must still be able to reach MAX+1 for every class.
  if (MUL_MAX >= (1 << CW) - 1 || DIVU_MAX >= (1 << CW) - 1 ||
      DIVS_MAX >= (1 << CW) - 1) begin : g_bad_cw
    $error("muldiv_lat_mon: CW too small for the configured latency bounds");
  end

  logic acc, rsp, is_dup, is_ovf, record;
  logic [DEPTH-1:0]    live, hit, dup_hit, avail, alloc, kill_free, free;
  logic [DEPTH-1:0]    ent_early, ent_late, ent_tmo;
  logic [MAX_TAGW-1:0] ent_tag [DEPTH];
  logic [3:0]          ent_fn  [DEPTH];
  logic [CW-1:0]       ent_lat [DEPTH];
  logic [DEPTH-1:0]    last_alloc_q;
  logic [PW-1:0]       pend;

  logic          lat_valid_q, lat_valid_d;
  logic [CW-1:0] lat_cycles_q, lat_cycles_d;
  logic [3:0]    lat_fn_q, lat_fn_d;
  logic          err_early_q, err_early_d, err_late_q, err_late_d;
  logic          err_timeout_q, err_timeout_d, err_orphan_q, err_orphan_d;
  logic          err_dup_q, err_dup_d, err_ovf_q, err_ovf_d, err_any_q, err_any_d;

  assign acc = mon.req_valid & mon.req_ready;
  assign rsp = mon.resp_valid & mon.resp_ready;

  // Tag CAM; an entry hit by this cycle's response is no duplicate source.
  always_comb begin
    hit     = '0;
    dup_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i]     = rsp && live[i] && (ent_tag[i] == MAX_TAGW'(mon.resp_tag));
      dup_hit[i] = acc && live[i] && !hit[i] && (ent_tag[i] == MAX_TAGW'(mon.req_tag));
    end
  end

  assign avail  = ~live | hit;
  assign is_dup = |dup_hit;
  assign is_ovf = acc && (avail == '0);
  assign record = acc && !is_dup && !is_ovf;

  always_comb begin
    alloc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (record && avail[i]) begin
        alloc = DEPTH'(1) << i;
      end
    end
  end

  assign kill_free = {DEPTH{mon.kill}} & last_alloc_q & live & ~hit;
  assign free      = hit | kill_free;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    muldiv_lat_entry #(
      .TAGW(TAGW), .CW(CW),
      .MUL_MIN(MUL_MIN), .MUL_MAX(MUL_MAX),
      .DIVU_MIN(DIVU_MIN), .DIVU_MAX(DIVU_MAX),
      .DIVS_MIN(DIVS_MIN), .DIVS_MAX(DIVS_MAX)
    ) u_entry (
      .clock    (clock),
      .reset    (reset),
      .alloc_i  (alloc[g]),
      .free_i   (free[g]),
      .fn_i     (mon.req_fn),
      .tag_i    (mon.req_tag),
      .live_o   (live[g]),
      .tag_o    (ent_tag[g]),
      .fn_o     (ent_fn[g]),
      .lat_o    (ent_lat[g]),
      .early_o  (ent_early[g]),
      .late_o   (ent_late[g]),
      .timeout_o(ent_tmo[g])
    );
  end

  always_comb begin
    lat_cycles_d = '0;
    lat_fn_d     = '0;
    err_early_d  = 1'b0;
    err_late_d   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i]) begin
        lat_cycles_d = ent_lat[i];
        lat_fn_d     = ent_fn[i];
        err_early_d  = ent_early[i];
        err_late_d   = ent_late[i];
      end
    end
    lat_valid_d   = |hit;
    err_orphan_d  = rsp && !(|hit);
    err_timeout_d = |ent_tmo;
    err_dup_d     = is_dup;
    err_ovf_d     = is_ovf;
    err_any_d     = err_early_d | err_late_d | err_orphan_d | err_timeout_d |
                    err_dup_d | err_ovf_d;
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend = pend + PW'(live[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_valid_q   <= 1'b0;
      lat_cycles_q  <= '0;
      lat_fn_q      <= '0;
      err_early_q   <= 1'b0;
      err_late_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_orphan_q  <= 1'b0;
      err_dup_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_any_q     <= 1'b0;
      last_alloc_q  <= '0;
    end else begin
      lat_valid_q   <= lat_valid_d;
      lat_cycles_q  <= lat_cycles_d;
      lat_fn_q      <= lat_fn_d;
      err_early_q   <= err_early_d;
      err_late_q    <= err_late_d;
      err_timeout_q <= err_timeout_d;
      err_orphan_q  <= err_orphan_d;
      err_dup_q     <= err_dup_d;
      err_ovf_q     <= err_ovf_d;
      err_any_q     <= err_any_q | err_any_d;
      last_alloc_q  <= alloc;
    end
  end

  assign mon.lat_valid    = lat_valid_q;
  assign mon.lat_cycles   = lat_cycles_q;
  assign mon.lat_fn       = lat_fn_q;
  assign mon.pending      = pend;
  assign mon.err_early    = err_early_q;
  assign mon.err_late     = err_late_q;
  assign mon.err_timeout  = err_timeout_q;
  assign mon.err_orphan   = err_orphan_q;
  assign mon.err_dup      = err_dup_q;
  assign mon.err_overflow = err_ovf_q;
  assign mon.err_any      = err_any_q;

endmodule

// File: tb/tb_muldiv_lat_mon.sv
// Bench for muldiv_lat_mon: directed scenarios then random traffic, each cycle
// compared against a cycle-count based reference model of outstanding requests.
module tb_muldiv_lat_mon;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TAGW  = 5;
  localparam int CW    = 8;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int SATV  = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  muldiv_lat_mon_if #(.TAGW(TAGW), .CW(CW), .PW(PW)) bus ();

  muldiv_lat_mon #(.XLEN(XLEN), .DEPTH(DEPTH), .TAGW(TAGW), .CW(CW)) dut (
    .clock(clock),
    .reset(reset),
    .mon  (bus.slave)
  );

  int nAsserts = 0;
  int nFails   = 0;
  int cyc      = 0;

  // Model: each outstanding request remembers the cycle it was accepted in.
  bit mLive  [DEPTH];
  int mTag   [DEPTH];
  int mFn    [DEPTH];
  int mStart [DEPTH];
  int lastSlot = -1;

  int expLatValid, expLatCycles, expLatFn, expEarly, expLate, expTimeout;
  int expOrphan, expDup, expOverflow, expErrAny, expPending;
  bit chkData = 1'b0;

  task automatic getBounds(input int fn, output int mn, output int mx);
    if (((fn >> 2) & 1) == 0) begin
      mn = XLEN + 1; mx = XLEN + 1;
    end else if ((fn & 1) == 1) begin
      mn = XLEN + 2; mx = XLEN + 2;
    end else begin
      mn = XLEN + 2; mx = XLEN + 4;
    end
  endtask

  task automatic checkOne(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("lat_valid", 32'(bus.lat_valid), 32'(expLatValid));
    if (expLatValid != 0 || chkData) begin
      checkOne("lat_cycles", 32'(bus.lat_cycles), 32'(expLatCycles));
      checkOne("lat_fn", 32'(bus.lat_fn), 32'(expLatFn));
    end
    checkOne("err_early", 32'(bus.err_early), 32'(expEarly));
    checkOne("err_late", 32'(bus.err_late), 32'(expLate));
    checkOne("err_timeout", 32'(bus.err_timeout), 32'(expTimeout));
    checkOne("err_orphan", 32'(bus.err_orphan), 32'(expOrphan));
    checkOne("err_dup", 32'(bus.err_dup), 32'(expDup));
    checkOne("err_overflow", 32'(bus.err_overflow), 32'(expOverflow));
    checkOne("err_any", 32'(bus.err_any), 32'(expErrAny));
    checkOne("pending", 32'(bus.pending), 32'(expPending));
  endtask

  task automatic clearExp();
    expLatValid = 0; expLatCycles = 0; expLatFn = 0; expEarly = 0; expLate = 0;
    expTimeout = 0; expOrphan = 0; expDup = 0; expOverflow = 0;
  endtask

  task automatic driveBus(input int reqV, input int reqRdy, input int fn, input int tag,
                          input int killIn, input int respV, input int respRdy, input int rTag);
    bus.req_valid  = (reqV != 0);
    bus.req_ready  = (reqRdy != 0);
    bus.req_fn     = 4'(fn);
    bus.req_tag    = TAGW'(tag);
    bus.kill       = (killIn != 0);
    bus.resp_valid = (respV != 0);
    bus.resp_ready = (respRdy != 0);
    bus.resp_tag   = TAGW'(rTag);
  endtask

  task automatic applyStimulus(input int reqV, input int reqRdy, input int fn, input int tag,
                               input int killIn, input int respV, input int respRdy, input int rTag);
    int hitSlot, killSlot, newSlot, liveCnt, mn, mx, age;
    bit acc, rsp, dup;
    driveBus(reqV, reqRdy, fn, tag, killIn, respV, respRdy, rTag);
    acc = (reqV != 0) && (reqRdy != 0);
    rsp = (respV != 0) && (respRdy != 0);
    clearExp();

    hitSlot = -1;
    for (int i = 0; i < DEPTH; i++)
      if (rsp && mLive[i] && mTag[i] == (rTag & ((1 << TAGW) - 1))) hitSlot = i;

    for (int i = 0; i < DEPTH; i++) begin
      if (mLive[i] && i != hitSlot) begin
        getBounds(mFn[i], mn, mx);
        if (cyc - mStart[i] == mx) expTimeout = 1;
      end
    end

    if (hitSlot >= 0) begin
      age = cyc - mStart[hitSlot];
      if (age > SATV) age = SATV;
      getBounds(mFn[hitSlot], mn, mx);
      expLatValid  = 1;
      expLatCycles = age;
      expLatFn     = mFn[hitSlot];
      expEarly     = (age < mn) ? 1 : 0;
      expLate      = (age > mx) ? 1 : 0;
      mLive[hitSlot] = 1'b0;
    end else if (rsp) begin
      expOrphan = 1;
    end

    killSlot = -1;
    if (killIn != 0 && lastSlot >= 0 && mLive[lastSlot]) killSlot = lastSlot;

    dup = 1'b0;
    liveCnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mLive[i]) begin
        liveCnt++;
        if (mTag[i] == (tag & ((1 << TAGW) - 1))) dup = 1'b1;
      end
    end
    newSlot = -1;
    if (acc) begin
      expDup      = dup ? 1 : 0;
      expOverflow = (liveCnt == DEPTH) ? 1 : 0;
      if (!dup && liveCnt < DEPTH) begin
        for (int i = DEPTH - 1; i >= 0; i--) if (!mLive[i]) newSlot = i;
        mLive[newSlot]  = 1'b1;
        mTag[newSlot]   = tag & ((1 << TAGW) - 1);
        mFn[newSlot]    = fn & 15;
        mStart[newSlot] = cyc;
      end
    end
    if (killSlot >= 0) mLive[killSlot] = 1'b0;
    lastSlot = newSlot;

    if ((expEarly | expLate | expTimeout | expOrphan | expDup | expOverflow) != 0) expErrAny = 1;
    expPending = 0;
    for (int i = 0; i < DEPTH; i++) if (mLive[i]) expPending++;

    @(posedge clock);
    cyc++;
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic resetDut();
    driveBus(0, 1, 0, 0, 0, 0, 1, 0);
    reset = 1'b1;
    @(posedge clock);
    cyc++;
    #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) mLive[i] = 1'b0;
    lastSlot = -1;
    clearExp();
    expErrAny  = 0;
    expPending = 0;
    chkData = 1'b1;
    checkOutput();
    chkData = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    resetDut();

    $display("[TB] mul latency 33");
    applyStimulus(1, 1, 0, 3, 0, 0, 1, 0);
    idle(32);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 3);
    checkOne("mul33_lat", 32'(bus.lat_cycles), 32'd33);
    checkOne("mul33_any", 32'(bus.err_any), 32'd0);

    $display("[TB] signed divide at 34, 36, 37");
    applyStimulus(1, 1, 6, 4, 0, 0, 1, 0);
    idle(33);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 4);
    applyStimulus(1, 1, 6, 5, 0, 0, 1, 0);
    idle(35);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 5);
    checkOne("divs36_lat", 32'(bus.lat_cycles), 32'd36);
    applyStimulus(1, 1, 6, 6, 0, 0, 1, 0);
    idle(36);
    checkOne("divs_timeout", 32'(bus.err_timeout), 32'd1);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 6);
    checkOne("divs_late", 32'(bus.err_late), 32'd1);
    checkOne("divs37_lat", 32'(bus.lat_cycles), 32'd37);

    $display("[TB] unsigned divide early at 20");
    applyStimulus(1, 1, 5, 8, 0, 0, 1, 0);
    idle(19);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 8);
    checkOne("divu_early", 32'(bus.err_early), 32'd1);
    checkOne("divu_lat", 32'(bus.lat_cycles), 32'd20);
    idle(3);
    checkOne("err_any_sticky", 32'(bus.err_any), 32'd1);

    $display("[TB] overflow and same-cycle reuse");
    resetDut();
    for (int t = 1; t <= 4; t++) applyStimulus(1, 1, 0, t, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 5, 0, 0, 1, 0);
    checkOne("ovf_pulse", 32'(bus.err_overflow), 32'd1);
    checkOne("ovf_pending", 32'(bus.pending), 32'd4);
    applyStimulus(1, 1, 0, 1, 0, 1, 1, 1);
    checkOne("reuse_nodup", 32'(bus.err_dup), 32'd0);
    checkOne("reuse_pending", 32'(bus.pending), 32'd4);
    applyStimulus(1, 1, 2, 3, 0, 0, 1, 0);
    checkOne("dup_pulse", 32'(bus.err_dup), 32'd1);
    for (int t = 1; t <= 4; t++) applyStimulus(0, 1, 0, 0, 0, 1, 1, t);

    $display("[TB] kill then orphan");
    applyStimulus(1, 1, 4, 7, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 0);
    checkOne("kill_pending", 32'(bus.pending), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 7);
    checkOne("kill_orphan", 32'(bus.err_orphan), 32'd1);
    checkOne("kill_novalid", 32'(bus.lat_valid), 32'd0);

    $display("[TB] reset with live entries");
    for (int t = 10; t <= 12; t++) applyStimulus(1, 1, 1, t, 0, 0, 1, 0);
    checkOne("pre_reset_pending", 32'(bus.pending), 32'd3);
    resetDut();
    idle(2);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 10);
    checkOne("old_tag_orphan", 32'(bus.err_orphan), 32'd1);

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      int rq, rr, fn, tg, kl, rs, sr, rt, slot;
      rq   = ($urandom_range(0, 99) < 45) ? 1 : 0;
      rr   = ($urandom_range(0, 99) < 85) ? 1 : 0;
      fn   = int'($urandom_range(0, 15));
      tg   = int'($urandom_range(0, 7));
      kl   = ($urandom_range(0, 99) < 8) ? 1 : 0;
      rs   = ($urandom_range(0, 99) < 12) ? 1 : 0;
      sr   = ($urandom_range(0, 99) < 90) ? 1 : 0;
      slot = int'($urandom_range(0, DEPTH - 1));
      rt   = (mLive[slot] && $urandom_range(0, 9) < 8) ? mTag[slot] : int'($urandom_range(0, 7));
      applyStimulus(rq, rr, fn, tg, kl, rs, sr, rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
